// File: rtl/sirv_sram_icb_arbt2_pkg.sv
// Shared widths, arbitration-scheme constants and the lock state for the
// two-port SRAM ICB arbiter.
package sirv_sram_icb_arbt2_pkg;
  localparam int ICB_AW    = 32;
  localparam int ICB_DW    = 32;
  localparam int ICB_MW    = ICB_DW / 8;
  localparam int ICB_USR_W = 3;

  localparam bit ARBT_FIXED       = 1'b0;
  localparam bit ARBT_ROUND_ROBIN = 1'b1;

  typedef enum logic {ARB_OPEN = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  // A depth-1 FIFO still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sirv_sram_icb_arbt2_if.sv
// One ICB link: command channel plus response channel.
interface sirv_sram_icb_arbt2_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int MW    = 4,
  parameter int USR_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_read;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [MW-1:0]    cmd_wmask;
  logic [USR_W-1:0] cmd_usr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic [USR_W-1:0] rsp_usr;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_usr
  );
  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_usr
  );
endinterface

// File: rtl/sirv_sram_icb_arbt_idfifo.sv
// DP-entry x 1-bit in-order FIFO holding the port ID of each outstanding command.
module sirv_sram_icb_arbt_idfifo
  import sirv_sram_icb_arbt2_pkg::*;
#(
  parameter int DP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int PW = ptr_w(DP);
  localparam int CW = $clog2(DP + 1);

  logic [DP-1:0] mem;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == CW'(DP));
  assign empty   = (cnt == '0);
  assign dout    = mem[rptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/sirv_sram_icb_arbt2.sv
// Two-port ICB arbiter in front of an in-order SRAM controller; an ID FIFO
// steers each response back to the port whose command was granted.
module sirv_sram_icb_arbt2
  import sirv_sram_icb_arbt2_pkg::*;
#(
  parameter int AW         = ICB_AW,
  parameter int DW         = ICB_DW,
  parameter int MW         = ICB_MW,
  parameter int USR_W      = ICB_USR_W,
  parameter int OUTS_DEPTH = 2,
  parameter bit ARBT_RR    = ARBT_ROUND_ROBIN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sirv_sram_icb_arbt2_if.slave  i0_icb,
  sirv_sram_icb_arbt2_if.slave  i1_icb,
  sirv_sram_icb_arbt2_if.master o_icb,
  output logic                 arbt_active
);
  arb_state_e       state_q;
  logic             lock_id_q, rr_q, gnt;
  logic             v0, v1, cmd_hsk, rsp_hsk;
  logic             fifo_full, fifo_empty, fifo_head;
  logic [AW-1:0]    addr_mux;
  logic [DW-1:0]    wdata_mux;
  logic [MW-1:0]    wmask_mux;
  logic [USR_W-1:0] usr_mux;

  assign v0 = i0_icb.cmd_valid;
  assign v1 = i1_icb.cmd_valid;

  // A stalled downstream command keeps its port so the payload cannot change.
  always_comb begin
    if (state_q == ARB_LOCKED) gnt = lock_id_q;
    else if (v0 && v1)         gnt = (ARBT_RR == ARBT_FIXED) ? 1'b0 : rr_q;
    else                       gnt = v1;
  end

  always_comb begin
    addr_mux  = gnt ? i1_icb.cmd_addr  : i0_icb.cmd_addr;
    wdata_mux = gnt ? i1_icb.cmd_wdata : i0_icb.cmd_wdata;
    wmask_mux = gnt ? i1_icb.cmd_wmask : i0_icb.cmd_wmask;
    usr_mux   = gnt ? i1_icb.cmd_usr   : i0_icb.cmd_usr;
  end

  assign o_icb.cmd_valid = (v0 | v1) & ~fifo_full;
  assign o_icb.cmd_read  = gnt ? i1_icb.cmd_read : i0_icb.cmd_read;
  assign o_icb.cmd_addr  = addr_mux;
  assign o_icb.cmd_wdata = wdata_mux;
  assign o_icb.cmd_wmask = wmask_mux;
  assign o_icb.cmd_usr   = usr_mux;

  assign i0_icb.cmd_ready = ~gnt & o_icb.cmd_ready & ~fifo_full;
  assign i1_icb.cmd_ready =  gnt & o_icb.cmd_ready & ~fifo_full;
  assign cmd_hsk          = o_icb.cmd_valid & o_icb.cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b0;
    end else if (cmd_hsk) begin
      state_q <= ARB_OPEN;
      rr_q    <= ~gnt;
    end else if (o_icb.cmd_valid) begin
      state_q   <= ARB_LOCKED;
      lock_id_q <= gnt;
    end
  end

  sirv_sram_icb_arbt_idfifo #(.DP(OUTS_DEPTH)) u_idfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hsk),
    .din   (gnt),
    .pop   (rsp_hsk),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Responses are only ever accepted against an outstanding ID.
  assign o_icb.rsp_ready  = ~fifo_empty & (fifo_head ? i1_icb.rsp_ready : i0_icb.rsp_ready);
  assign rsp_hsk          = o_icb.rsp_valid & o_icb.rsp_ready;
  assign i0_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty & ~fifo_head;
  assign i1_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty &  fifo_head;
  assign i0_icb.rsp_rdata = o_icb.rsp_rdata;
  assign i1_icb.rsp_rdata = o_icb.rsp_rdata;
  assign i0_icb.rsp_usr   = o_icb.rsp_usr;
  assign i1_icb.rsp_usr   = o_icb.rsp_usr;

  assign arbt_active = v0 | v1 | ~fifo_empty | (state_q == ARB_LOCKED);

  a_rsp_needs_id: assert property (@(posedge clk) disable iff (!rst_n)
    !(o_icb.rsp_valid && fifo_empty)) else $error("response with no outstanding command");
endmodule

// File: tb/tb_sirv_sram_icb_arbt2.sv
// Bench for the two-port ICB arbiter: directed scenarios plus a random run
// checked against a queue-based model of grants and outstanding IDs.
module tb_sirv_sram_icb_arbt2;
  localparam int AW = 32, DW = 32, MW = 4, UW = 3, DEPTH = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic r_act, f_act;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sirv_sram_icb_arbt2_if #(.AW(AW), .DW(DW), .MW(MW), .USR_W(UW)) r_i0 (), r_i1 (), r_o ();
  sirv_sram_icb_arbt2_if #(.AW(AW), .DW(DW), .MW(MW), .USR_W(UW)) f_i0 (), f_i1 (), f_o ();

  sirv_sram_icb_arbt2 #(.AW(AW), .DW(DW), .MW(MW), .USR_W(UW), .OUTS_DEPTH(DEPTH), .ARBT_RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .i0_icb(r_i0), .i1_icb(r_i1), .o_icb(r_o), .arbt_active(r_act));
  sirv_sram_icb_arbt2 #(.AW(AW), .DW(DW), .MW(MW), .USR_W(UW), .OUTS_DEPTH(DEPTH), .ARBT_RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .i0_icb(f_i0), .i1_icb(f_i1), .o_icb(f_o), .arbt_active(f_act));

  task automatic idle();
    r_i0.cmd_valid = 0; r_i0.cmd_read = 0; r_i0.cmd_addr = '0; r_i0.cmd_wdata = '0; r_i0.cmd_wmask = '0; r_i0.cmd_usr = '0; r_i0.rsp_ready = 0;
    r_i1.cmd_valid = 0; r_i1.cmd_read = 0; r_i1.cmd_addr = '0; r_i1.cmd_wdata = '0; r_i1.cmd_wmask = '0; r_i1.cmd_usr = '0; r_i1.rsp_ready = 0;
    f_i0.cmd_valid = 0; f_i0.cmd_read = 0; f_i0.cmd_addr = '0; f_i0.cmd_wdata = '0; f_i0.cmd_wmask = '0; f_i0.cmd_usr = '0; f_i0.rsp_ready = 0;
    f_i1.cmd_valid = 0; f_i1.cmd_read = 0; f_i1.cmd_addr = '0; f_i1.cmd_wdata = '0; f_i1.cmd_wmask = '0; f_i1.cmd_usr = '0; f_i1.rsp_ready = 0;
    r_o.cmd_ready = 0; r_o.rsp_valid = 0; r_o.rsp_rdata = '0; r_o.rsp_usr = '0;
    f_o.cmd_ready = 0; f_o.rsp_valid = 0; f_o.rsp_rdata = '0; f_o.rsp_usr = '0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 0; idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (r_o.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_o_cmd_valid got=%0b exp=0", r_o.cmd_valid); end
    checks++; if ({r_i0.cmd_ready, r_i1.cmd_ready} !== 2'b00) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=00", {r_i0.cmd_ready, r_i1.cmd_ready}); end
    checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready} !== 3'b000) begin failures++; $display("FAIL reset_rsp got=%b exp=000", {r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready}); end
    checks++; if ({r_act, f_act} !== 2'b00) begin failures++; $display("FAIL reset_arbt_active got=%b exp=00", {r_act, f_act}); end
    checks++; if ({f_o.cmd_valid, f_i0.cmd_ready, f_i1.cmd_ready} !== 3'b000) begin failures++; $display("FAIL reset_fp_cmd got=%b exp=000", {f_o.cmd_valid, f_i0.cmd_ready, f_i1.cmd_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    do_reset();
    r_i0.cmd_valid = 1; r_i0.cmd_read = 1; r_i0.cmd_addr = 32'h10; r_i0.cmd_usr = 3'd4; r_o.cmd_ready = 1;
    @(negedge clk);
    checks++; if ({r_o.cmd_valid, r_o.cmd_read, r_i0.cmd_ready, r_i1.cmd_ready} !== 4'b1110) begin failures++; $display("FAIL rd_cmd_hsk got=%b exp=1110", {r_o.cmd_valid, r_o.cmd_read, r_i0.cmd_ready, r_i1.cmd_ready}); end
    checks++; if (r_o.cmd_addr !== 32'h10) begin failures++; $display("FAIL rd_cmd_addr got=%0h exp=10", r_o.cmd_addr); end
    @(posedge clk); #1;
    r_i0.cmd_valid = 0; r_o.rsp_valid = 1; r_o.rsp_rdata = 32'hA5A5A5A5; r_o.rsp_usr = 3'd4; r_i0.rsp_ready = 1;
    @(negedge clk);
    checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready} !== 3'b101) begin failures++; $display("FAIL rd_rsp_route got=%b exp=101", {r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready}); end
    checks++; if (r_i0.rsp_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL rd_rsp_rdata got=%0h exp=a5a5a5a5", r_i0.rsp_rdata); end
    @(posedge clk); #1;
    r_o.rsp_valid = 0;
    @(negedge clk);
    checks++; if ({r_act, r_i1.rsp_valid} !== 2'b00) begin failures++; $display("FAIL rd_drained got=%b exp=00", {r_act, r_i1.rsp_valid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit pend[$];
    bit eg, rsp;
    do_reset();
    r_i0.cmd_valid = 1; r_i0.cmd_read = 1; r_i0.cmd_addr = 32'h40; r_i0.cmd_usr = 3'b001;
    r_i1.cmd_valid = 1; r_i1.cmd_read = 0; r_i1.cmd_addr = 32'h80; r_i1.cmd_usr = 3'b010;
    r_o.cmd_ready = 1; r_i0.rsp_ready = 1; r_i1.rsp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      eg = c[0];
      rsp = pend.size() > 0;
      r_o.rsp_valid = rsp; r_o.rsp_rdata = 32'(c);
      r_o.rsp_usr = rsp ? (pend[0] ? 3'b010 : 3'b001) : 3'b000;
      @(negedge clk);
      checks++; if ({r_i0.cmd_ready, r_i1.cmd_ready} !== {~eg, eg}) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, {r_i0.cmd_ready, r_i1.cmd_ready}, {~eg, eg}); end
      checks++; if (r_o.cmd_usr !== (eg ? 3'b010 : 3'b001)) begin failures++; $display("FAIL rr_cmd_usr c=%0d got=%0d exp=%0d", c, r_o.cmd_usr, eg ? 2 : 1); end
      if (rsp) begin
        checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid} !== {~pend[0], pend[0]}) begin failures++; $display("FAIL rr_rsp_route c=%0d got=%b exp=%b", c, {r_i0.rsp_valid, r_i1.rsp_valid}, {~pend[0], pend[0]}); end
        checks++; if ((pend[0] ? r_i1.rsp_usr : r_i0.rsp_usr) !== (pend[0] ? 3'b010 : 3'b001)) begin failures++; $display("FAIL rr_rsp_usr c=%0d got=%0d exp=%0d", c, pend[0] ? r_i1.rsp_usr : r_i0.rsp_usr, pend[0] ? 2 : 1); end
        void'(pend.pop_front());
      end
      pend.push_back(eg);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fixed_prio();
    int pend;
    do_reset();
    f_i0.cmd_valid = 1; f_i0.cmd_read = 1; f_i0.cmd_addr = 32'h40; f_i0.cmd_usr = 3'b001;
    f_i1.cmd_valid = 1; f_i1.cmd_read = 0; f_i1.cmd_addr = 32'h80; f_i1.cmd_usr = 3'b010;
    f_o.cmd_ready = 1; f_i0.rsp_ready = 1; f_i1.rsp_ready = 1;
    pend = 0;
    for (int c = 0; c < 6; c++) begin
      f_o.rsp_valid = (pend > 0); f_o.rsp_usr = 3'b001;
      @(negedge clk);
      checks++; if ({f_i0.cmd_ready, f_i1.cmd_ready, f_o.cmd_usr} !== 5'b10_001) begin failures++; $display("FAIL fp_grant c=%0d got=%b exp=10001", c, {f_i0.cmd_ready, f_i1.cmd_ready, f_o.cmd_usr}); end
      if (pend > 0) begin
        checks++; if ({f_i0.rsp_valid, f_i1.rsp_valid} !== 2'b10) begin failures++; $display("FAIL fp_rsp_route c=%0d got=%b exp=10", c, {f_i0.rsp_valid, f_i1.rsp_valid}); end
      end
      pend = 1;
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    r_i1.cmd_valid = 1; r_i1.cmd_addr = 32'h100; r_i1.cmd_usr = 3'b010; r_o.cmd_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin r_i0.cmd_valid = 1; r_i0.cmd_addr = 32'h200; r_i0.cmd_usr = 3'b001; end
      @(negedge clk);
      checks++; if ({r_o.cmd_valid, r_i0.cmd_ready, r_i1.cmd_ready} !== 3'b100) begin failures++; $display("FAIL lock_stall c=%0d got=%b exp=100", c, {r_o.cmd_valid, r_i0.cmd_ready, r_i1.cmd_ready}); end
      checks++; if ({r_o.cmd_addr, r_o.cmd_usr} !== {32'h100, 3'b010}) begin failures++; $display("FAIL lock_payload c=%0d got=%0h/%0d exp=100/2", c, r_o.cmd_addr, r_o.cmd_usr); end
      @(posedge clk); #1;
    end
    r_o.cmd_ready = 1;
    @(negedge clk);
    checks++; if ({r_i0.cmd_ready, r_i1.cmd_ready, r_o.cmd_addr} !== {2'b01, 32'h100}) begin failures++; $display("FAIL lock_release got=%b/%0h exp=01/100", {r_i0.cmd_ready, r_i1.cmd_ready}, r_o.cmd_addr); end
    @(posedge clk); #1;
    r_i1.cmd_valid = 0;
    @(negedge clk);
    checks++; if ({r_i0.cmd_ready, r_o.cmd_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL lock_next got=%b/%0h exp=1/200", r_i0.cmd_ready, r_o.cmd_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_outstanding_full();
    do_reset();
    r_i0.cmd_valid = 1; r_o.cmd_ready = 1; r_i0.rsp_ready = 1;
    for (int c = 0; c < 2; c++) begin
      r_i0.cmd_addr = 32'h10 + 32'(4 * c);
      @(negedge clk);
      checks++; if (r_i0.cmd_ready !== 1'b1) begin failures++; $display("FAIL full_fill c=%0d got=%b exp=1", c, r_i0.cmd_ready); end
      @(posedge clk); #1;
    end
    r_i0.cmd_addr = 32'h18; r_o.rsp_valid = 1; r_o.rsp_rdata = 32'h11;
    @(negedge clk);
    checks++; if ({r_o.cmd_valid, r_i0.cmd_ready, r_o.rsp_ready} !== 3'b001) begin failures++; $display("FAIL full_block got=%b exp=001", {r_o.cmd_valid, r_i0.cmd_ready, r_o.rsp_ready}); end
    @(posedge clk); #1;
    r_o.rsp_valid = 0;
    @(negedge clk);
    checks++; if ({r_o.cmd_valid, r_i0.cmd_ready} !== 2'b11) begin failures++; $display("FAIL full_reopen got=%b exp=11", {r_o.cmd_valid, r_i0.cmd_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_rsp_stall();
    do_reset();
    r_i0.cmd_valid = 1; r_i0.cmd_addr = 32'h20; r_o.cmd_ready = 1;
    @(negedge clk);
    checks++; if (r_i0.cmd_ready !== 1'b1) begin failures++; $display("FAIL stall_cmd0 got=%b exp=1", r_i0.cmd_ready); end
    @(posedge clk); #1;
    r_i0.cmd_valid = 0; r_i1.cmd_valid = 1; r_i1.cmd_addr = 32'h24; r_i1.cmd_usr = 3'd2;
    r_o.rsp_valid = 1; r_o.rsp_rdata = 32'h1234; r_o.rsp_usr = 3'd3; r_i0.rsp_ready = 0; r_i1.rsp_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) r_i1.cmd_addr = 32'h28;
      @(negedge clk);
      checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready} !== 3'b100) begin failures++; $display("FAIL stall_hold c=%0d got=%b exp=100", c, {r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready}); end
      checks++; if (r_i1.cmd_ready !== (c == 0)) begin failures++; $display("FAIL stall_cmd1 c=%0d got=%b exp=%b", c, r_i1.cmd_ready, c == 0); end
      @(posedge clk); #1;
    end
    r_i0.rsp_ready = 1;
    @(negedge clk);
    checks++; if ({r_i0.rsp_valid, r_o.rsp_ready, r_i0.rsp_rdata} !== {2'b11, 32'h1234}) begin failures++; $display("FAIL stall_release got=%b/%0h exp=11/1234", {r_i0.rsp_valid, r_o.rsp_ready}, r_i0.rsp_rdata); end
    @(posedge clk); #1;
    r_o.rsp_rdata = 32'h5678;
    @(negedge clk);
    checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready, r_i1.cmd_ready} !== 4'b0111) begin failures++; $display("FAIL stall_next_head got=%b exp=0111", {r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready, r_i1.cmd_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit            mq[$];
    logic [DW-1:0] dq_rd[$];
    logic [UW-1:0] dq_usr[$];
    bit            pv[2], prd[2];
    logic [AW-1:0] pa[2];
    logic [UW-1:0] pu[2];
    bit lk, lk_id, rr, g, ordy, rv, rr0, rr1, full, empty, h;
    bit e_ov, e_r0, e_r1, e_rv0, e_rv1, e_ordy, e_act;
    do_reset();
    lk = 0; lk_id = 0; rr = 0; pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p] && $urandom_range(1, 0) == 1) begin
          pv[p] = 1; pa[p] = $urandom; pu[p] = UW'($urandom_range(7, 0)); prd[p] = 1'($urandom_range(1, 0));
        end
      ordy = $urandom_range(9, 0) < 7;
      rv   = (mq.size() > 0) && ($urandom_range(9, 0) < 6);
      rr0  = 1'($urandom_range(1, 0)); rr1 = 1'($urandom_range(1, 0));
      r_i0.cmd_valid = pv[0]; r_i0.cmd_read = prd[0]; r_i0.cmd_addr = pa[0]; r_i0.cmd_usr = pu[0];
      r_i0.cmd_wdata = pa[0] ^ 32'h5A5A5A5A; r_i0.cmd_wmask = pa[0][3:0]; r_i0.rsp_ready = rr0;
      r_i1.cmd_valid = pv[1]; r_i1.cmd_read = prd[1]; r_i1.cmd_addr = pa[1]; r_i1.cmd_usr = pu[1];
      r_i1.cmd_wdata = pa[1] ^ 32'h5A5A5A5A; r_i1.cmd_wmask = pa[1][3:0]; r_i1.rsp_ready = rr1;
      r_o.cmd_ready = ordy; r_o.rsp_valid = rv;
      r_o.rsp_rdata = rv ? dq_rd[0] : $urandom; r_o.rsp_usr = rv ? dq_usr[0] : '0;

      full  = mq.size() == DEPTH;
      empty = mq.size() == 0;
      if (lk) g = lk_id;
      else if (pv[0] && pv[1]) g = rr;
      else g = pv[1];
      h      = empty ? 1'b0 : mq[0];
      e_ov   = (pv[0] || pv[1]) && !full;
      e_r0   = !g && ordy && !full;
      e_r1   =  g && ordy && !full;
      e_rv0  = rv && !empty && !h;
      e_rv1  = rv && !empty &&  h;
      e_ordy = !empty && (h ? rr1 : rr0);
      e_act  = pv[0] || pv[1] || !empty || lk;

      @(negedge clk);
      checks++; if ({r_o.cmd_valid, r_i0.cmd_ready, r_i1.cmd_ready} !== {e_ov, e_r0, e_r1}) begin failures++; $display("FAIL rnd_cmd c=%0d got=%b exp=%b", c, {r_o.cmd_valid, r_i0.cmd_ready, r_i1.cmd_ready}, {e_ov, e_r0, e_r1}); end
      if (e_ov) begin
        checks++;
        if ({r_o.cmd_addr, r_o.cmd_usr, r_o.cmd_read, r_o.cmd_wdata, r_o.cmd_wmask} !== {pa[g], pu[g], prd[g], pa[g] ^ 32'h5A5A5A5A, pa[g][3:0]}) begin
          failures++; $display("FAIL rnd_payload c=%0d got=%0h/%0d exp=%0h/%0d (port %0d)", c, r_o.cmd_addr, r_o.cmd_usr, pa[g], pu[g], g);
        end
      end
      checks++; if ({r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready} !== {e_rv0, e_rv1, e_ordy}) begin failures++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, {r_i0.rsp_valid, r_i1.rsp_valid, r_o.rsp_ready}, {e_rv0, e_rv1, e_ordy}); end
      if (rv) begin
        checks++; if ({r_i0.rsp_rdata, r_i1.rsp_usr} !== {dq_rd[0], dq_usr[0]}) begin failures++; $display("FAIL rnd_rsp_data c=%0d got=%0h/%0d exp=%0h/%0d", c, r_i0.rsp_rdata, r_i1.rsp_usr, dq_rd[0], dq_usr[0]); end
      end
      checks++; if (r_act !== e_act) begin failures++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, r_act, e_act); end

      if (e_ov && ordy) begin
        mq.push_back(g); dq_rd.push_back($urandom); dq_usr.push_back(pu[g]);
        pv[g] = 0; lk = 0; rr = !g;
      end else if (e_ov) begin
        lk = 1; lk_id = g;
      end
      if (rv && e_ordy) begin
        void'(mq.pop_front()); void'(dq_rd.pop_front()); void'(dq_usr.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset with IDs still outstanding must drop them all.
  task automatic test_reset_mid();
    r_i0.cmd_valid = 1; r_i0.cmd_addr = 32'h300; r_o.cmd_ready = 1;
    @(posedge clk); #1;
    rst_n = 0; r_i0.cmd_valid = 0; r_i1.cmd_valid = 0; r_o.cmd_ready = 0;
    @(posedge clk); #1;
    r_o.rsp_valid = 1; r_i0.rsp_ready = 1; r_i1.rsp_ready = 1;
    @(negedge clk);
    checks++; if ({r_act, r_o.rsp_ready, r_i0.rsp_valid, r_i1.rsp_valid} !== 4'b0000) begin failures++; $display("FAIL mid_reset got=%b exp=0000", {r_act, r_o.rsp_ready, r_i0.rsp_valid, r_i1.rsp_valid}); end
    @(posedge clk); #1;
    idle(); rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_lock();
    test_outstanding_full();
    test_rsp_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
